// File: rtl/projection_sequencer_if.sv
// rtl/projection_sequencer_if.sv - Triangle, projector and 2D-triangle signal bundle for projection_sequencer
//
// Vertex packing (30 bits): [29:20] x, [19:10] y, [9:0] z.
//   3D vertices: x, y, z signed.
//   2D vertices: x, y unsigned screen coordinates, z passed through.
// Modports:
//   master - triangle source, projector and rasterizer side (drives tri_*, proj_v2d, out_ready)
//   slave  - the sequencer
interface projection_sequencer_if #(
  parameter int CNT_W = 16
);
  logic               tri_valid;
  logic               tri_ready;
  logic [29:0]        tri_v0;
  logic [29:0]        tri_v1;
  logic [29:0]        tri_v2;
  logic [29:0]        proj_v3d;
  logic [29:0]        proj_v2d;
  logic               out_valid;
  logic               out_ready;
  logic [29:0]        out_v0;
  logic [29:0]        out_v1;
  logic [29:0]        out_v2;
  logic signed [22:0] out_area;
  logic               busy;
  logic [CNT_W-1:0]   near_rej_cnt;
  logic [CNT_W-1:0]   cull_cnt;
  logic [CNT_W-1:0]   tri_out_cnt;

  modport master (
    output tri_valid, tri_v0, tri_v1, tri_v2, proj_v2d, out_ready,
    input  tri_ready, proj_v3d, out_valid, out_v0, out_v1, out_v2, out_area,
           busy, near_rej_cnt, cull_cnt, tri_out_cnt
  );

  modport slave (
    input  tri_valid, tri_v0, tri_v1, tri_v2, proj_v2d, out_ready,
    output tri_ready, proj_v3d, out_valid, out_v0, out_v1, out_v2, out_area,
           busy, near_rej_cnt, cull_cnt, tri_out_cnt
  );
endinterface

// File: rtl/projection_sequencer.sv
// rtl/projection_sequencer.sv - Time-shares one vertex projector across the three vertices of a triangle
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - projection_sequencer_if.slave: triangle in (tri_*), projector
//          (proj_v3d out, proj_v2d in), 2D triangle out (out_*), busy and
//          wrapping near-reject / cull / emitted-triangle counters.
module projection_sequencer #(
  parameter int PROJ_LATENCY = 1,
  parameter int CULL_EN      = 1,
  parameter int NEAR_Z_MIN   = -399,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  projection_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PROJ, CULL, OUT} state_t;

  localparam int            WW        = (PROJ_LATENCY > 0) ? $clog2(PROJ_LATENCY + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(PROJ_LATENCY);

  function automatic logic z_below(input logic [29:0] v);
    return int'($signed(v[9:0])) < NEAR_Z_MIN;
  endfunction

  state_t             state_q;
  logic               tri_ready_q, busy_q, out_valid_q;
  logic [1:0]         idx_q;
  logic [WW-1:0]      wait_q;
  logic [29:0]        v0_q, v1_q, v2_q;
  logic [29:0]        r0_q, r1_q, r2_q;
  logic [29:0]        proj_q;
  logic [29:0]        out_v0_q, out_v1_q, out_v2_q;
  logic signed [22:0] area_q;
  logic [CNT_W-1:0]   near_rej_q, cull_q, tri_out_q;

  logic               near_rej_d;
  logic signed [22:0] dx1_d, dy1_d, dx2_d, dy2_d, area_d;

  assign near_rej_d = z_below(bus.tri_v0) || z_below(bus.tri_v1) || z_below(bus.tri_v2);

  // Screen coordinates are unsigned, so zero-extend before taking differences.
  assign dx1_d  = 23'($signed({1'b0, r1_q[29:20]})) - 23'($signed({1'b0, r0_q[29:20]}));
  assign dy1_d  = 23'($signed({1'b0, r1_q[19:10]})) - 23'($signed({1'b0, r0_q[19:10]}));
  assign dx2_d  = 23'($signed({1'b0, r2_q[29:20]})) - 23'($signed({1'b0, r0_q[29:20]}));
  assign dy2_d  = 23'($signed({1'b0, r2_q[19:10]})) - 23'($signed({1'b0, r0_q[19:10]}));
  assign area_d = (dx1_d * dy2_d) - (dx2_d * dy1_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tri_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= 2'd0;
      wait_q      <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      r0_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      proj_q      <= '0;
      out_v0_q    <= '0;
      out_v1_q    <= '0;
      out_v2_q    <= '0;
      area_q      <= '0;
      near_rej_q  <= '0;
      cull_q      <= '0;
      tri_out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tri_valid) begin
            if (near_rej_d) begin
              // Rejected triangles never touch the projector input.
              near_rej_q <= near_rej_q + CNT_W'(1);
            end else begin
              v0_q        <= bus.tri_v0;
              v1_q        <= bus.tri_v1;
              v2_q        <= bus.tri_v2;
              // Present v0 now so a zero-latency projector answers in the first PROJ cycle.
              proj_q      <= bus.tri_v0;
              idx_q       <= 2'd0;
              wait_q      <= '0;
              state_q     <= PROJ;
              tri_ready_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        PROJ: begin
          if (wait_q == WAIT_LAST) begin
            wait_q <= '0;
            case (idx_q)
              2'd0: begin
                r0_q   <= bus.proj_v2d;
                proj_q <= v1_q;
                idx_q  <= 2'd1;
              end
              2'd1: begin
                r1_q   <= bus.proj_v2d;
                proj_q <= v2_q;
                idx_q  <= 2'd2;
              end
              default: begin
                r2_q    <= bus.proj_v2d;
                state_q <= CULL;
              end
            endcase
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        CULL: begin
          out_v0_q <= r0_q;
          out_v1_q <= r1_q;
          out_v2_q <= r2_q;
          area_q   <= area_d;
          // Degenerate (zero-area) triangles are culled along with back faces.
          if ((CULL_EN != 0) && (area_d <= 23'sd0)) begin
            cull_q      <= cull_q + CNT_W'(1);
            state_q     <= IDLE;
            tri_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          if (bus.out_ready) begin
            tri_out_q   <= tri_out_q + CNT_W'(1);
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            tri_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.tri_ready    = tri_ready_q;
  assign bus.busy         = busy_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.proj_v3d     = proj_q;
  assign bus.out_v0       = out_v0_q;
  assign bus.out_v1       = out_v1_q;
  assign bus.out_v2       = out_v2_q;
  assign bus.out_area     = area_q;
  assign bus.near_rej_cnt = near_rej_q;
  assign bus.cull_cnt     = cull_q;
  assign bus.tri_out_cnt  = tri_out_q;
endmodule

// File: doc/projection_sequencer.md
Name: projection_sequencer

Overview:
- Triangle-level controller that time-shares one vertex projector, a perspective-divide unit with a fixed pipeline latency, across the three vertices of each incoming 3D triangle.
- Accepts a 3D triangle and rejects it if it crosses the near plane.
- Issues each vertex to the projector in turn and captures the projected 2D vertices.
- Computes the signed screen-space area, optionally back-face culls, then presents the 2D triangle to the rasterizer setup stage with valid/ready.

Parameters:
- PROJ_LATENCY, 1: cycles from a stable proj_v3d to a valid proj_v2d (0 = combinational projector).
- CULL_EN, 1: when 1, triangles with area <= 0 are discarded.
- NEAR_Z_MIN, -399: minimum legal signed vertex z; the projector divides by z+400, so z below -399 is illegal.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- tri_valid  in  1  input triangle valid.
- tri_ready  out  1  sequencer can accept a triangle.
- tri_v0, tri_v1, tri_v2  in  30 each (vertex_3d_t)  signed 10-bit x, y, z.
- proj_v3d  out  30 (vertex_3d_t)  vertex driven to the projector.
- proj_v2d  in  30 (vertex_2d_t)  projector result.
- out_valid  out  1  2D triangle valid.
- out_ready  in  1  downstream accepts.
- out_v0, out_v1, out_v2  out  30 each (vertex_2d_t)  projected vertices; z passed through.
- out_area  out  23 signed  twice the signed screen area.
- busy  out  1  state != IDLE.
- near_rej_cnt  out  CNT_W  count of near-plane rejects, wrapping.
- cull_cnt  out  CNT_W  count of back-face culls, wrapping.
- tri_out_cnt  out  CNT_W  count of emitted triangles, wrapping.

Behaviour:
- Reset values:
  - State IDLE; tri_ready=1; out_valid=0; busy=0.
  - out_v*, out_area, proj_v3d and all counters = 0.
  - Reset mid-operation drops the in-flight triangle silently; no counter increments.
- States: IDLE, PROJ, CULL, OUT.
- IDLE:
  - tri_ready=1 only in IDLE.
  - On tri_valid&tri_ready: latch tri_v0..2.
  - If any vertex z < NEAR_Z_MIN (signed compare): near_rej_cnt++, stay IDLE. A back-to-back accept on the next cycle is allowed.
  - Otherwise go to PROJ with idx=0, wait counter=0.
- PROJ:
  - proj_v3d = latched v[idx], held stable for PROJ_LATENCY+1 cycles.
  - When counter==PROJ_LATENCY: capture proj_v2d into result[idx] and clear the counter.
  - If idx==2, go to CULL; otherwise idx++.
  - Each vertex costs exactly PROJ_LATENCY+1 cycles.
- CULL (1 cycle):
  - Inputs: x,y zero-extended to 11-bit signed.
  - dx1=x1-x0, dy1=y1-y0, dx2=x2-x0, dy2=y2-y0.
  - area = dx1*dy2 - dx2*dy1 in 23-bit signed. This cannot overflow because coordinates are ≤639/479.
  - Register area into out_area and results into out_v*.
  - If CULL_EN and area<=0 (degenerate included): cull_cnt++, go to IDLE, out_valid never rises.
  - Otherwise go to OUT.
- OUT:
  - out_valid=1; out_v*/out_area held stable until out_ready.
  - On out_valid&out_ready: tri_out_cnt++, go to IDLE.
  - out_valid must not drop without a handshake.
- Latency:
  - Acceptance edge = cycle 0.
  - out_valid first high in cycle 3*(PROJ_LATENCY+1)+2; with PROJ_LATENCY=1 that is cycle 8.
  - The next triangle can be accepted the cycle after the output handshake.
  - Throughput with out_ready tied 1: one triangle per 3*(PROJ_LATENCY+1)+3 cycles.
- proj_v3d holds its last value outside PROJ. The projector is not assumed to have a valid input there.
- Counters wrap from 2^CNT_W-1 to 0.

Test Plan:
- Bench wraps the projector in PROJ_LATENCY register stages. The projector computes x*400/(z+400)+320 and y*400/(z+400)+240, each clamped to 0–639 / 0–479.
1. Front-facing triangle, PROJ_LATENCY=1, out_ready=1:
   - In: v0=(0,0,0), v1=(100,0,0), v2=(0,100,0).
   - Expect out (320,240),(420,240),(320,340); out_area=+10000.
   - out_valid high in cycle 8 for 1 cycle; tri_out_cnt=1.
2. Back-face cull: same triangle with v1/v2 swapped.
   - Expect area=-10000, no out_valid, cull_cnt=1, busy low at cycle 8.
   - CULL_EN=0 run: triangle emitted with out_area=-10000.
3. Near plane:
   - v1.z=-400: near_rej_cnt=1, tri_ready stays 1, no projector activity.
   - v1.z=-399, x=1: accepted, x clamps to 639.
4. Backpressure: out_ready=0 for 20 cycles in case 1.
   - out_valid and out_v*/out_area stable throughout; tri_ready=0.
   - Handshake on the first out_ready=1 cycle.
5. Reset mid-PROJ: assert rst at cycle 3 of case 1.
   - All outputs return to reset values immediately; counters 0.
   - A fresh triangle afterwards completes normally.
6. PROJ_LATENCY=0 and PROJ_LATENCY=3 builds with three back-to-back triangles:
   - First out_valid at cycles 5 and 14 respectively.
   - Results match case 1; tri_out_cnt=3.
